// File: rtl/temp_sensor_controller.sv
// Command/response sequencer for the single-wire temperature sensor: sends a fixed read
// command through the byte encoder, collects a 3-byte reply and publishes checked readings.
module temp_sensor_controller #(
   parameter int                     MAX_BYTES        = 5,
   parameter int                     CMD_LEN          = 2,
   parameter logic [MAX_BYTES*8-1:0] CMD_WORD         = 'h55A1,
   parameter int                     RESP_LEN         = 3,
   parameter int                     POLL_PERIOD      = 1000000,
   parameter int                     TX_START_TIMEOUT = 64,
   parameter int                     TX_END_GAP       = 4,
   parameter int                     RESP_TIMEOUT     = 4096
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   tx_switch,
   input  logic [7:0]             rx_byte,
   input  logic                   rx_valid,
   output logic [MAX_BYTES*8-1:0] tx_bytes,
   output logic [3:0]             tx_num_bytes,
   output logic                   tx_valid,
   output logic [15:0]            temperature,
   output logic                   temp_valid,
   output logic                   crc_error,
   output logic                   timeout_error,
   output logic                   busy
);

   localparam int PW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam int TMAX = (TX_START_TIMEOUT > RESP_TIMEOUT) ? TX_START_TIMEOUT : RESP_TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int GW   = $clog2(TX_END_GAP + 1);
   localparam int BW   = $clog2(RESP_LEN + 1);

   localparam logic [PW-1:0] POLL_LAST  = PW'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);
   localparam logic [TW-1:0] START_LAST = TW'(TX_START_TIMEOUT - 1);
   localparam logic [TW-1:0] RESP_LAST  = TW'(RESP_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_END    = GW'(TX_END_GAP);
   localparam logic [BW-1:0] BYTE_LAST  = BW'(RESP_LEN - 1);

   typedef enum logic [2:0] {IDLE, SEND, WAIT_TX_START, WAIT_TX_END, RX, CHECK} state_t;

   state_t            state, state_next;
   logic [PW-1:0]     poll_cnt;
   logic [TW-1:0]     wait_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [BW-1:0]     byte_idx;
   logic [7:0]        rx_buf [RESP_LEN];
   logic [MAX_BYTES*8-1:0] cmd_vec;
   logic              poll_hit;
   logic              start_tmo;
   logic              resp_tmo;
   logic              crc_ok;

   // Command bytes left-aligned, unused trailing bytes padded with 8'hFF.
   for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_cmd
      if (gi < CMD_LEN) begin : g_used
         assign cmd_vec[(MAX_BYTES-1-gi)*8 +: 8] = CMD_WORD[(CMD_LEN-1-gi)*8 +: 8];
      end else begin : g_pad
         assign cmd_vec[(MAX_BYTES-1-gi)*8 +: 8] = 8'hFF;
      end
   end

   assign poll_hit = (POLL_PERIOD != 0) && (poll_cnt == POLL_LAST);
   assign crc_ok   = (rx_buf[RESP_LEN-1] == (rx_buf[0] ^ rx_buf[1]));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      start_tmo  = 1'b0;
      resp_tmo   = 1'b0;
      case (state)
         IDLE:          if (start || poll_hit) state_next = SEND;
         SEND:          state_next = WAIT_TX_START;
         WAIT_TX_START: begin
            if (tx_switch) begin
               state_next = WAIT_TX_END;
            end else if (wait_cnt == START_LAST) begin
               start_tmo  = 1'b1;
               state_next = IDLE;
            end
         end
         WAIT_TX_END:   if (gap_cnt == GAP_END) state_next = RX;
         RX: begin
            // A byte arriving on the timeout cycle is dropped.
            if (wait_cnt == RESP_LAST && byte_idx < BW'(RESP_LEN)) begin
               resp_tmo   = 1'b1;
               state_next = IDLE;
            end else if (rx_valid && byte_idx == BYTE_LAST) begin
               state_next = CHECK;
            end
         end
         CHECK:         state_next = IDLE;
         default:       state_next = IDLE;
      endcase
   end

   assign timeout_error = start_tmo | resp_tmo;
   assign busy          = (state != IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         poll_cnt <= '0;
         wait_cnt <= '0;
         gap_cnt  <= '0;
         byte_idx <= '0;
      end else begin
         poll_cnt <= (state == IDLE && state_next == IDLE) ? poll_cnt + 1'b1 : '0;
         wait_cnt <= (state_next == state && (state == WAIT_TX_START || state == RX))
                     ? wait_cnt + 1'b1 : '0;
         gap_cnt  <= (state == WAIT_TX_END && state_next == WAIT_TX_END && !tx_switch)
                     ? gap_cnt + 1'b1 : '0;
         if (state != RX)                       byte_idx <= '0;
         else if (rx_valid && !resp_tmo)        byte_idx <= byte_idx + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (state == RX && rx_valid && !resp_tmo && byte_idx < BW'(RESP_LEN))
         rx_buf[byte_idx] <= rx_byte;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_bytes     <= '0;
         tx_num_bytes <= '0;
         tx_valid     <= 1'b0;
         temperature  <= 16'h0000;
         temp_valid   <= 1'b0;
         crc_error    <= 1'b0;
      end else begin
         tx_valid   <= (state_next == SEND);
         temp_valid <= (state == CHECK) && crc_ok;
         crc_error  <= (state == CHECK) && !crc_ok;
         if (state_next == SEND) begin
            tx_bytes     <= cmd_vec;
            tx_num_bytes <= 4'(CMD_LEN);
         end else if (state_next == IDLE) begin
            tx_bytes     <= '0;
            tx_num_bytes <= '0;
         end
         if (state == CHECK && crc_ok)
            temperature <= {rx_buf[0], rx_buf[1]};
      end
   end

endmodule
